// File: rtl/sdram_req_sched.sv
// sdram_req_sched: buffers user write/read requests in two FIFOs and
// feeds them one at a time to a single-cycle SDRAM controller port.
//
// Ports:
//   i_sys_clk, i_rst_n            clock, synchronous active-low reset
//   i_wr_valid/o_wr_ready         user write push (i_wr_addr, i_wr_data)
//   i_rd_valid/o_rd_ready         user read push (i_rd_addr)
//   o_rsp_valid/o_rsp_data        read data return, one-cycle pulse
//   i_ctrl_ready                  controller can accept a request
//   o_ctrl_wr_req/addr/data       write request to controller
//   o_ctrl_rd_req/addr            read request to controller
//   i_ctrl_rd_valid/data          read data from controller
//
// Build option: define SDRAM_REQ_SCHED_RAW_CHECK_EN to hold a read back
// while any buffered write targets the same address.

module sdram_req_sched #(
   parameter int AddrWidth   = 13,
   parameter int DataWidth   = 16,
   parameter int FifoDepth   = 4,
   parameter int MaxRdStreak = 3
) (
   input  logic                 i_sys_clk,
   input  logic                 i_rst_n,
   input  logic                 i_wr_valid,
   output logic                 o_wr_ready,
   input  logic [AddrWidth-1:0] i_wr_addr,
   input  logic [DataWidth-1:0] i_wr_data,
   input  logic                 i_rd_valid,
   output logic                 o_rd_ready,
   input  logic [AddrWidth-1:0] i_rd_addr,
   output logic                 o_rsp_valid,
   output logic [DataWidth-1:0] o_rsp_data,
   input  logic                 i_ctrl_ready,
   output logic                 o_ctrl_wr_req,
   output logic [AddrWidth-1:0] o_ctrl_wr_addr,
   output logic [DataWidth-1:0] o_ctrl_wr_data,
   output logic                 o_ctrl_rd_req,
   output logic [AddrWidth-1:0] o_ctrl_rd_addr,
   input  logic                 i_ctrl_rd_valid,
   input  logic [DataWidth-1:0] i_ctrl_rd_data
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int StkW = $clog2(MaxRdStreak + 1);

   localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(FifoDepth);
   localparam logic [StkW-1:0] StreakMax = StkW'(MaxRdStreak);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      WAIT_RD
   } state_t;

   state_t state;

   logic [StkW-1:0] streak;

   // FIFO storage (no reset needed; validity comes from the pointers)
   logic [AddrWidth-1:0] wf_addr [FifoDepth];
   logic [DataWidth-1:0] wf_data [FifoDepth];
   logic [AddrWidth-1:0] rf_addr [FifoDepth];

   // Pointers carry one extra bit so full and empty differ
   logic [PtrW:0] wf_wp;
   logic [PtrW:0] wf_rp;
   logic [PtrW:0] rf_wp;
   logic [PtrW:0] rf_rp;

   logic [PtrW:0] wf_wp_nx;
   logic [PtrW:0] wf_rp_nx;
   logic [PtrW:0] rf_wp_nx;
   logic [PtrW:0] rf_rp_nx;

   logic wf_push;
   logic rf_push;
   logic wf_empty;
   logic rf_empty;
   logic wf_full;
   logic hazard;
   logic issue_wr;
   logic issue_rd;

   logic [AddrWidth-1:0] rd_head;

   assign wf_push = i_wr_valid & o_wr_ready;
   assign rf_push = i_rd_valid & o_rd_ready;

   assign wf_empty = (wf_wp == wf_rp);
   assign rf_empty = (rf_wp == rf_rp);
   assign wf_full  = (wf_wp - wf_rp) == LevelFull;

   assign rd_head = rf_addr[rf_rp[PtrW-1:0]];

   assign wf_wp_nx = wf_wp + (PtrW + 1)'(wf_push);
   assign wf_rp_nx = wf_rp + (PtrW + 1)'(issue_wr);
   assign rf_wp_nx = rf_wp + (PtrW + 1)'(rf_push);
   assign rf_rp_nx = rf_rp + (PtrW + 1)'(issue_rd);

`ifdef SDRAM_REQ_SCHED_RAW_CHECK_EN
   logic [PtrW:0] wf_level;

   assign wf_level = wf_wp - wf_rp;

   // Match the read head against every occupied write slot
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
         if (!rf_empty &&
             ((PtrW + 1)'(i) < wf_level) &&
             (wf_addr[wf_rp[PtrW-1:0] + PtrW'(i)] == rd_head))
            hazard = 1'b1;
      end
   end
`else
   assign hazard = 1'b0;
`endif

   // Pick at most one request per idle cycle, first match wins
   always_comb begin
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      if (state == IDLE && i_ctrl_ready &&
          !(wf_empty && rf_empty)) begin
         if (wf_full)
            issue_wr = 1'b1;
         else if (hazard)
            issue_wr = 1'b1;
         else if (streak == StreakMax && !wf_empty)
            issue_wr = 1'b1;
         else if (!rf_empty)
            issue_rd = 1'b1;
         else
            issue_wr = 1'b1;
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (wf_push) begin
         wf_addr[wf_wp[PtrW-1:0]] <= i_wr_addr;
         wf_data[wf_wp[PtrW-1:0]] <= i_wr_data;
      end
      if (rf_push)
         rf_addr[rf_wp[PtrW-1:0]] <= i_rd_addr;
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         streak         <= '0;
         wf_wp          <= '0;
         wf_rp          <= '0;
         rf_wp          <= '0;
         rf_rp          <= '0;
         o_wr_ready     <= 1'b0;
         o_rd_ready     <= 1'b0;
         o_rsp_valid    <= 1'b0;
         o_rsp_data     <= '0;
         o_ctrl_wr_req  <= 1'b0;
         o_ctrl_wr_addr <= '0;
         o_ctrl_wr_data <= '0;
         o_ctrl_rd_req  <= 1'b0;
         o_ctrl_rd_addr <= '0;
      end else begin
         wf_wp <= wf_wp_nx;
         wf_rp <= wf_rp_nx;
         rf_wp <= rf_wp_nx;
         rf_rp <= rf_rp_nx;

         // Ready reflects the level after this cycle's push and pop
         o_wr_ready <= (wf_wp_nx - wf_rp_nx) != LevelFull;
         o_rd_ready <= (rf_wp_nx - rf_rp_nx) != LevelFull;

         o_ctrl_wr_req <= 1'b0;
         o_ctrl_rd_req <= 1'b0;
         o_rsp_valid   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (issue_wr) begin
                  o_ctrl_wr_req  <= 1'b1;
                  o_ctrl_wr_addr <= wf_addr[wf_rp[PtrW-1:0]];
                  o_ctrl_wr_data <= wf_data[wf_rp[PtrW-1:0]];
                  streak         <= '0;
                  state          <= HOLD;
               end else if (issue_rd) begin
                  o_ctrl_rd_req  <= 1'b1;
                  o_ctrl_rd_addr <= rd_head;
                  // Streak only counts reads that bypass waiting writes
                  if (wf_empty)
                     streak <= '0;
                  else if (streak != StreakMax)
                     streak <= streak + 1'b1;
                  state <= WAIT_RD;
               end
            end
            HOLD: begin
               state <= IDLE;
            end
            WAIT_RD: begin
               if (i_ctrl_rd_valid) begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_data  <= i_ctrl_rd_data;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_req_sched.sv
// tb_sdram_req_sched: vector table, directed ordering sequences and a
// randomized run, all also checked each cycle against a queue model.

module tb_sdram_req_sched;

   localparam int AW  = 13;
   localparam int DW  = 16;
   localparam int FD  = 4;
   localparam int MRS = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          ctrl_ready = 1'b0;
   logic          ctrl_rd_valid = 1'b0;
   logic [DW-1:0] ctrl_rd_data = '0;

   logic          o_wr_ready;
   logic          o_rd_ready;
   logic          o_rsp_valid;
   logic [DW-1:0] o_rsp_data;
   logic          o_ctrl_wr_req;
   logic [AW-1:0] o_ctrl_wr_addr;
   logic [DW-1:0] o_ctrl_wr_data;
   logic          o_ctrl_rd_req;
   logic [AW-1:0] o_ctrl_rd_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int log_q[$];

   sdram_req_sched #(
      .AddrWidth(AW), .DataWidth(DW),
      .FifoDepth(FD), .MaxRdStreak(MRS)
   ) dut (
      .i_sys_clk(clk),
      .i_rst_n(rst_n),
      .i_wr_valid(wr_valid),
      .o_wr_ready(o_wr_ready),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .i_rd_valid(rd_valid),
      .o_rd_ready(o_rd_ready),
      .i_rd_addr(rd_addr),
      .o_rsp_valid(o_rsp_valid),
      .o_rsp_data(o_rsp_data),
      .i_ctrl_ready(ctrl_ready),
      .o_ctrl_wr_req(o_ctrl_wr_req),
      .o_ctrl_wr_addr(o_ctrl_wr_addr),
      .o_ctrl_wr_data(o_ctrl_wr_data),
      .o_ctrl_rd_req(o_ctrl_rd_req),
      .o_ctrl_rd_addr(o_ctrl_rd_addr),
      .i_ctrl_rd_valid(ctrl_rd_valid),
      .i_ctrl_rd_data(ctrl_rd_data)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [62:0] dut_out();
      return {o_wr_ready, o_rd_ready, o_rsp_valid, o_rsp_data,
              o_ctrl_wr_req, o_ctrl_wr_addr, o_ctrl_wr_data,
              o_ctrl_rd_req, o_ctrl_rd_addr};
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } went_t;

   went_t         mq_w[$];
   logic [AW-1:0] mq_r[$];
   bit            m_hold = 0;
   bit            m_wait = 0;
   int            m_streak = 0;

   logic          e_wrdy = 0, e_rrdy = 0, e_rsp = 0;
   logic          e_wreq = 0, e_rreq = 0;
   logic [DW-1:0] e_rspd = '0, e_wd = '0;
   logic [AW-1:0] e_wa = '0, e_ra = '0;

   function automatic logic [62:0] exp_out();
      return {e_wrdy, e_rrdy, e_rsp, e_rspd, e_wreq, e_wa, e_wd,
              e_rreq, e_ra};
   endfunction

   function automatic bit raw_hit();
`ifdef SDRAM_REQ_SCHED_RAW_CHECK_EN
      if (mq_r.size() == 0) return 0;
      foreach (mq_w[i])
         if (mq_w[i].a == mq_r[0]) return 1;
`endif
      return 0;
   endfunction

   task automatic model_step();
      bit pw, pr, do_w, do_r;
      went_t ent;
      if (!rst_n) begin
         mq_w.delete();
         mq_r.delete();
         m_hold = 0; m_wait = 0; m_streak = 0;
         e_wrdy = 0; e_rrdy = 0; e_rsp = 0; e_rspd = '0;
         e_wreq = 0; e_wa = '0; e_wd = '0;
         e_rreq = 0; e_ra = '0;
         return;
      end
      pw = wr_valid && e_wrdy;
      pr = rd_valid && e_rrdy;
      do_w = 0; do_r = 0;
      e_wreq = 0; e_rreq = 0; e_rsp = 0;
      if (m_hold) begin
         m_hold = 0;
      end else if (m_wait) begin
         if (ctrl_rd_valid) begin
            e_rsp = 1; e_rspd = ctrl_rd_data; m_wait = 0;
         end
      end else if (ctrl_ready && (mq_w.size() + mq_r.size() > 0)) begin
         if (mq_w.size() == FD || raw_hit() ||
             (m_streak == MRS && mq_w.size() > 0))
            do_w = 1;
         else if (mq_r.size() > 0)
            do_r = 1;
         else
            do_w = 1;
      end
      if (do_w) begin
         ent = mq_w.pop_front();
         e_wreq = 1; e_wa = ent.a; e_wd = ent.d;
         m_streak = 0; m_hold = 1;
      end
      if (do_r) begin
         e_rreq = 1; e_ra = mq_r.pop_front();
         if (mq_w.size() == 0) m_streak = 0;
         else if (m_streak < MRS) m_streak++;
         m_wait = 1;
      end
      if (pw) begin
         ent.a = wr_addr; ent.d = wr_data;
         mq_w.push_back(ent);
      end
      if (pr) mq_r.push_back(rd_addr);
      e_wrdy = (mq_w.size() != FD);
      e_rrdy = (mq_r.size() != FD);
   endtask

   // Per-cycle check against the model, plus an issue log
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (o_ctrl_wr_req) log_q.push_back(32'h10000 | int'(o_ctrl_wr_addr));
         if (o_ctrl_rd_req) log_q.push_back(32'h20000 | int'(o_ctrl_rd_addr));
         chk("model", {1'b0, dut_out()}, {1'b0, exp_out()});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      wr_valid = 0; rd_valid = 0; ctrl_ready = 0; ctrl_rd_valid = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic push_wr(input int a, input int d);
      bit acc;
      int k = 0;
      wr_valid = 1; wr_addr = AW'(a); wr_data = DW'(d);
      do begin
         acc = o_wr_ready;
         tick();
         k++;
      end while (!acc && k < 100);
      wr_valid = 0;
      chk("push_wr_accept", 64'(acc), 64'd1);
   endtask

   task automatic push_rd(input int a);
      bit acc;
      int k = 0;
      rd_valid = 1; rd_addr = AW'(a);
      do begin
         acc = o_rd_ready;
         tick();
         k++;
      end while (!acc && k < 100);
      rd_valid = 0;
      chk("push_rd_accept", 64'(acc), 64'd1);
   endtask

   // Controller stand-in: returns read data 4 cycles after a request
   task automatic run_drain(input int cycles);
      int cnt = 0;
      ctrl_ready = 1;
      for (int k = 0; k < cycles; k++) begin
         tick();
         ctrl_rd_valid = 0;
         if (o_ctrl_rd_req) begin
            cnt = 3;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               ctrl_rd_valid = 1;
               ctrl_rd_data = DW'($urandom);
            end
         end
      end
      ctrl_rd_valid = 0;
   endtask

   function automatic bit log_has_w(input int base);
      for (int i = base; i < log_q.size(); i++)
         if ((log_q[i] >> 16) == 1) return 1;
      return 0;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic          r, wv, rv, cr, cv;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, cd;
      logic          ewr, err, ers, ewq, erq;
      logic [DW-1:0] erd, ewd;
      logic [AW-1:0] ewa, era;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t row(
      input logic r, wv, input int wa, wd,
      input logic rv, input int ra, input logic cr, cv, input int cd,
      input logic ewr, err, ers, input int erd,
      input logic ewq, input int ewa, ewd,
      input logic erq, input int era);
      vec_t v;
      v.r = r; v.wv = wv; v.wa = AW'(wa); v.wd = DW'(wd);
      v.rv = rv; v.ra = AW'(ra); v.cr = cr; v.cv = cv; v.cd = DW'(cd);
      v.ewr = ewr; v.err = err; v.ers = ers; v.erd = DW'(erd);
      v.ewq = ewq; v.ewa = AW'(ewa); v.ewd = DW'(ewd);
      v.erq = erq; v.era = AW'(era);
      return v;
   endfunction

   function automatic logic [62:0] vec_exp(input vec_t v);
      return {v.ewr, v.err, v.ers, v.erd, v.ewq, v.ewa, v.ewd,
              v.erq, v.era};
   endfunction

   // ---------------- main ----------------
   initial begin
      int base, nrsp;
      int exp_h[3];
      bit seen;
      string ord;

      // reset 3 cycles, single write, single read with late data
      vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vt.push_back(row(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vt.push_back(row(1,0,0,0, 0,0,0,0,0, 1,1,0,0, 0,0,0, 0,0));
      vt.push_back(row(1,1,'h10,'hBEEF, 0,0,1,0,0,
                       1,1,0,0, 0,0,0, 0,0));
      vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                       1,1,0,0, 1,'h10,'hBEEF, 0,0));
      vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                       1,1,0,0, 0,'h10,'hBEEF, 0,0));
      vt.push_back(row(1,0,0,0, 1,'h20,1,0,0,
                       1,1,0,0, 0,'h10,'hBEEF, 0,0));
      vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                       1,1,0,0, 0,'h10,'hBEEF, 1,'h20));
      vt.push_back(row(1,1,'h30,'h5555, 0,0,1,0,0,
                       1,1,0,0, 0,'h10,'hBEEF, 0,'h20));
      for (int i = 0; i < 3; i++)
         vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                          1,1,0,0, 0,'h10,'hBEEF, 0,'h20));
      vt.push_back(row(1,0,0,0, 0,0,1,1,'h1234,
                       1,1,1,'h1234, 0,'h10,'hBEEF, 0,'h20));
      vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                       1,1,0,'h1234, 1,'h30,'h5555, 0,'h20));
      vt.push_back(row(1,0,0,0, 0,0,1,0,0,
                       1,1,0,'h1234, 0,'h30,'h5555, 0,'h20));
      vt.push_back(row(1,0,0,0, 0,0,1,1,'hDEAD,
                       1,1,0,'h1234, 0,'h30,'h5555, 0,'h20));

      foreach (vt[i]) begin
         rst_n = vt[i].r;
         wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd;
         rd_valid = vt[i].rv; rd_addr = vt[i].ra;
         ctrl_ready = vt[i].cr;
         ctrl_rd_valid = vt[i].cv; ctrl_rd_data = vt[i].cd;
         tick();
         chk($sformatf("vec%0d", i), {1'b0, dut_out()},
             {1'b0, vec_exp(vt[i])});
      end

      // read-after-write hazard ordering
      do_reset();
      push_wr('h5, 'h1111);
      push_wr('h6, 'h2222);
      push_rd('h6);
      base = log_q.size();
      run_drain(30);
`ifdef SDRAM_REQ_SCHED_RAW_CHECK_EN
      exp_h[0] = 'h10005; exp_h[1] = 'h10006; exp_h[2] = 'h20006;
`else
      exp_h[0] = 'h20006; exp_h[1] = 'h10005; exp_h[2] = 'h10006;
`endif
      chk("hazard_count", 64'(log_q.size() - base), 64'd3);
      for (int i = 0; i < 3; i++)
         if (base + i < log_q.size())
            chk($sformatf("hazard_order%0d", i),
                64'(log_q[base+i]), 64'(exp_h[i]));

      // read streak limit while writes wait
      do_reset();
      wr_valid = 1; wr_addr = 'h100; wr_data = 'h0A00;
      rd_valid = 1; rd_addr = 'h200; tick();
      wr_addr = 'h101; rd_addr = 'h201; tick();
      wr_addr = 'h102; rd_addr = 'h202; tick();
      wr_valid = 0; rd_addr = 'h203; tick();
      rd_valid = 0;
      base = log_q.size();
      fork
         begin
            push_rd('h204);
            push_rd('h205);
         end
         begin
            seen = 0;
            for (int k = 0; k < 100 && !seen; k++) begin
               tick();
               seen = log_has_w(base);
            end
            push_wr('h103, 'h0A03);
         end
         run_drain(90);
      join
      ord = "RRRWRRRWWW";
      chk("streak_count", 64'(log_q.size() - base), 64'd10);
      for (int i = 0; i < ord.len(); i++)
         if (base + i < log_q.size())
            chk($sformatf("streak_order%0d", i),
                64'(log_q[base+i] >> 16),
                (ord[i] == "W") ? 64'd1 : 64'd2);

      // full write FIFO refuses a 5th push
      do_reset();
      for (int i = 0; i < 4; i++) push_wr('h40 + i, 'h7700 + i);
      chk("full_ready", 64'(o_wr_ready), 64'd0);
      wr_valid = 1; wr_addr = 'h1FF; wr_data = 'hFFFF;
      tick(); tick(); tick();
      chk("full_ready_held", 64'(o_wr_ready), 64'd0);
      wr_valid = 0;
      base = log_q.size();
      run_drain(20);
      chk("full_drain_count", 64'(log_q.size() - base), 64'd4);
      for (int i = 0; i < 4; i++)
         if (base + i < log_q.size())
            chk($sformatf("full_drain%0d", i),
                64'(log_q[base+i]), 64'('h10040 + i));

      // reset while a read is outstanding
      do_reset();
      push_rd('h2A);
      ctrl_ready = 1;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = o_ctrl_rd_req;
      end
      chk("rst_rd_issued", 64'(seen), 64'd1);
      tick();
      nrsp = 0;
      rst_n = 0;
      tick(); nrsp += int'(o_rsp_valid);
      tick(); nrsp += int'(o_rsp_valid);
      rst_n = 1;
      tick(); nrsp += int'(o_rsp_valid);
      ctrl_rd_valid = 1; ctrl_rd_data = 'hABCD;
      tick(); nrsp += int'(o_rsp_valid);
      ctrl_rd_valid = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         nrsp += int'(o_rsp_valid);
      end
      chk("rst_no_rsp", 64'(nrsp), 64'd0);
      chk("rst_rsp_data", 64'(o_rsp_data), 64'd0);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         wr_valid = $urandom_range(0, 2) == 0;
         wr_addr = AW'($urandom_range(0, 7));
         wr_data = DW'($urandom);
         rd_valid = $urandom_range(0, 2) == 0;
         rd_addr = AW'($urandom_range(0, 7));
         ctrl_ready = $urandom_range(0, 9) < 7;
         ctrl_rd_valid = $urandom_range(0, 3) == 0;
         ctrl_rd_data = DW'($urandom);
         tick();
      end
      wr_valid = 0; rd_valid = 0; ctrl_rd_valid = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdram_req_sched.md
# sdram_req_sched

Request scheduler sitting directly upstream of the SDRAM controller. Buffers user write and read requests in two small FIFOs, picks one request at a time and presents it to the controller's single-cycle request ports. Tracks the single outstanding read and returns its data to the user. Enforces read-after-write ordering against buffered writes and prevents write starvation.

## Interface
Parameters:
- AddrWidth, 13, request address width; matches the controller.
- DataWidth, 16, data width; matches the controller.
- FifoDepth, 4, entries per FIFO; must be a power of 2 and at least 2.
- MaxRdStreak, 3, maximum consecutive reads issued while writes are pending.

Ports:
- i_sys_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_wr_valid  in  1  user write request.
- o_wr_ready  out  1  write FIFO not full.
- i_wr_addr  in  AddrWidth  write address.
- i_wr_data  in  DataWidth  write data.
- i_rd_valid  in  1  user read request.
- o_rd_ready  out  1  read FIFO not full.
- i_rd_addr  in  AddrWidth  read address.
- o_rsp_valid  out  1  read data valid, one-cycle pulse; no backpressure.
- o_rsp_data  out  DataWidth  read data.
- i_ctrl_ready  in  1  controller idle and able to accept a request.
- o_ctrl_wr_req  out  1  write request to controller.
- o_ctrl_wr_addr  out  AddrWidth  write address to controller.
- o_ctrl_wr_data  out  DataWidth  write data to controller.
- o_ctrl_rd_req  out  1  read request to controller.
- o_ctrl_rd_addr  out  AddrWidth  read address to controller.
- i_ctrl_rd_valid  in  1  controller read data valid.
- i_ctrl_rd_data  in  DataWidth  controller read data.

## Operation
- **FIFO push:** accepted on `valid && ready`. `o_*_ready = !full`, registered. A push attempted while full is dropped; the user must hold `valid`.
- **FSM states:** IDLE, HOLD, WAIT_RD.
- **IDLE:**
  - Issue only when `i_ctrl_ready = 1` and at least one FIFO is non-empty.
  - Selection, first match wins:
    1. Write FIFO full: issue a write.
    2. Hazard (below): issue a write.
    3. Read streak counter equals MaxRdStreak and the write FIFO is non-empty: issue a write.
    4. Read FIFO non-empty: issue a read.
    5. Otherwise: issue a write.
- **Issue a write:** assert `o_ctrl_wr_req` for one cycle with the head entry; pop the write FIFO the same cycle; clear the streak counter; go to HOLD.
- **Issue a read:** assert `o_ctrl_rd_req` for one cycle; pop the read FIFO; increment the streak counter (saturates at MaxRdStreak; clears when the write FIFO is empty); go to WAIT_RD.
- **HOLD:** one cycle, with `i_ctrl_ready` ignored; then go to IDLE.
- **WAIT_RD:**
  - On `i_ctrl_rd_valid`: register `i_ctrl_rd_data` into `o_rsp_data` and pulse `o_rsp_valid` the next cycle; go to IDLE.
  - No new request is issued while in WAIT_RD.
- **Stray data:** `i_ctrl_rd_valid` outside WAIT_RD is ignored.
- **Output values:** `o_ctrl_*_addr`/`data` are registered and hold their last value when no request is asserted. `o_ctrl_wr_req` and `o_ctrl_rd_req` are never asserted together.
- **Reset values:** all FIFOs empty; `o_wr_ready = o_rd_ready = 0` during reset, 1 the first cycle after. `o_rsp_valid = 0`, `o_ctrl_wr_req = o_ctrl_rd_req = 0`, all address/data outputs 0, streak counter 0, FSM in IDLE.
- **Reset mid-operation:** buffered requests and any outstanding read are discarded; no response is produced for them.

## Timing
- **Issue latency:** a request pushed in cycle N, into empty FIFOs with `i_ctrl_ready` held high, appears on `o_ctrl_*_req` in cycle N+1.
- **Issue rate:** back-to-back writes are issued at most every 2 cycles (IDLE, HOLD).
- **Read response:** `o_rsp_valid` rises 1 cycle after `i_ctrl_rd_valid`.
- **Simultaneous push and pop on the same FIFO:** both occur, and the level is unchanged. On a full FIFO, the push is refused because ready was already low.
- **Pointers:** wrap modulo FifoDepth. Full and empty are distinguished with an extra pointer bit.

## Configuration
- **`SDRAM_REQ_SCHED_RAW_CHECK_EN` defined:** hazard = head read address equals the address of any valid write FIFO entry (full compare across FifoDepth entries). Writes drain until no match remains, guaranteeing read-after-write ordering.
- **Not defined:** hazard is constant 0. Ordering between reads and buffered writes is not guaranteed; only the full-FIFO and streak rules force writes.

## Test plan
- **Reset values:** reset for 3 cycles, then release → all outputs 0 during reset; `o_wr_ready = o_rd_ready = 1` the cycle after release.
- **Single write:** write addr 0x0010, data 0xBEEF, with `i_ctrl_ready = 1` → `o_ctrl_wr_req` for one cycle the next cycle, carrying 0x0010/0xBEEF.
- **Single read:** read addr 0x0020; controller returns 0x1234 five cycles after the request → `o_rsp_valid` one cycle later with 0x1234; no other request issued while waiting.
- **Hazard check:** push writes to 0x0005 and 0x0006, then a read of 0x0006, with the macro defined → both writes issued before the read. Without the macro → the read is issued first.
- **Starvation limit:** 4 writes and 6 reads queued, MaxRdStreak = 3, no address match → issue order R R R W R R R W W W.
- **Full FIFO and reset mid-read:** write FIFO filled to 4 with `i_ctrl_ready = 0` → `o_wr_ready = 0` and a 5th push is refused. Reset asserted during WAIT_RD → no `o_rsp_valid`, and a late `i_ctrl_rd_valid` is ignored.
